// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    SERVICE
  } state_e;

  localparam int unsigned IFID  = 0;
  localparam int unsigned IDEXE = 1;
  localparam int unsigned EXMEM = 2;
  localparam int unsigned MEMWB = 3;

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline <-> hazard controller signal bundle; master is the pipeline side.
interface hazard_controller_if #(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned REG_W      = 5,
  parameter int unsigned CNT_W      = 16
);
  logic [REG_W-1:0]      ID_RS;
  logic [REG_W-1:0]      ID_RT;
  logic                  ID_USES_RT;
  logic                  EX_MEMREAD;
  logic [REG_W-1:0]      EX_RD;
  logic                  BRANCH_TAKEN;
  logic                  SYSCALL_IN;
  logic                  SYSCALL_ACK;
  logic                  PC_STALL;
  logic [NUM_STAGES-1:0] STALL;
  logic [NUM_STAGES-1:0] FLUSH;
  logic                  SYSCALL_OUT;
  logic                  BUSY;
  logic [CNT_W-1:0]      STALL_CNT;

  modport master (
    output ID_RS, ID_RT, ID_USES_RT, EX_MEMREAD, EX_RD,
           BRANCH_TAKEN, SYSCALL_IN, SYSCALL_ACK,
    input  PC_STALL, STALL, FLUSH, SYSCALL_OUT, BUSY, STALL_CNT
  );

  modport slave (
    input  ID_RS, ID_RT, ID_USES_RT, EX_MEMREAD, EX_RD,
           BRANCH_TAKEN, SYSCALL_IN, SYSCALL_ACK,
    output PC_STALL, STALL, FLUSH, SYSCALL_OUT, BUSY, STALL_CNT
  );
endinterface

// File: rtl/hazard_loaduse_detect.sv
// Combinational load-use comparator: EX load feeding a source of the ID instruction.
module hazard_loaduse_detect #(
  parameter int unsigned REG_W = 5
) (
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  output logic             lu_o
);
  // Register 0 is hardwired to zero, so a load into it never creates a hazard.
  assign lu_o = ex_memread_i && (ex_rd_i != '0) &&
                ((ex_rd_i == id_rs_i) || (id_uses_rt_i && (ex_rd_i == id_rt_i)));
endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, branch squash, SYSCALL drain/service, stall counter.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned REG_W      = 5,
  parameter int unsigned CNT_W      = 16
) (
  input logic                CLOCK,
  input logic                RESET,
  hazard_controller_if.slave bus
);
  localparam int unsigned    DW         = $clog2(NUM_STAGES);
  localparam logic [DW-1:0]  DRAIN_LAST = DW'(NUM_STAGES - 2);

  state_e                state_q;
  logic [DW-1:0]         drain_q;
  logic                  sysout_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  lu;
  logic                  pc_stall;
  logic [NUM_STAGES-1:0] stall;
  logic [NUM_STAGES-1:0] flush;

  hazard_loaduse_detect #(.REG_W(REG_W)) u_lu (
    .ex_memread_i (bus.EX_MEMREAD),
    .ex_rd_i      (bus.EX_RD),
    .id_rs_i      (bus.ID_RS),
    .id_rt_i      (bus.ID_RT),
    .id_uses_rt_i (bus.ID_USES_RT),
    .lu_o         (lu)
  );

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= RUN;
      drain_q  <= '0;
      sysout_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          // A taken branch squashes the SYSCALL in ID as wrong-path.
          if (!bus.BRANCH_TAKEN && bus.SYSCALL_IN) begin
            state_q <= DRAIN;
            drain_q <= '0;
          end
        end
        DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_q  <= SERVICE;
            sysout_q <= 1'b1;
          end else begin
            drain_q <= drain_q + DW'(1);
          end
        end
        SERVICE: begin
          if (bus.SYSCALL_ACK) begin
            state_q  <= RUN;
            sysout_q <= 1'b0;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  always_comb begin
    pc_stall = 1'b0;
    stall    = '0;
    flush    = '0;
    case (state_q)
      RUN: begin
        if (bus.BRANCH_TAKEN) begin
          flush[IFID]  = 1'b1;
          flush[IDEXE] = 1'b1;
        end else if (bus.SYSCALL_IN || lu) begin
          pc_stall     = 1'b1;
          stall[IFID]  = 1'b1;
          flush[IDEXE] = 1'b1;
        end
      end
      DRAIN: begin
        pc_stall     = 1'b1;
        stall[IFID]  = 1'b1;
        flush[IFID]  = 1'b1;
        flush[IDEXE] = 1'b1;
      end
      SERVICE: begin
        pc_stall     = 1'b1;
        stall[IFID]  = 1'b1;
        flush[IDEXE] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      cnt_q <= '0;
    end else if (pc_stall && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.PC_STALL    = pc_stall;
  assign bus.STALL       = stall;
  assign bus.FLUSH       = flush;
  assign bus.SYSCALL_OUT = sysout_q;
  assign bus.BUSY        = (state_q != RUN);
  assign bus.STALL_CNT   = cnt_q;
endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: default instance plus a CNT_W=4 saturation instance.
module tb_hazard_controller;
  logic CLOCK;
  logic RESET;
  int   checks = 0;
  int   errors = 0;

  hazard_controller_if #(.NUM_STAGES(4), .REG_W(5), .CNT_W(16)) b0 ();
  hazard_controller_if #(.NUM_STAGES(4), .REG_W(5), .CNT_W(4))  b1 ();

  hazard_controller #(.NUM_STAGES(4), .REG_W(5), .CNT_W(16)) d0 (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (b0)
  );

  hazard_controller #(.NUM_STAGES(4), .REG_W(5), .CNT_W(4)) d1 (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (b1)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idle0();
    b0.ID_RS = '0; b0.ID_RT = '0; b0.ID_USES_RT = 1'b0; b0.EX_MEMREAD = 1'b0;
    b0.EX_RD = '0; b0.BRANCH_TAKEN = 1'b0; b0.SYSCALL_IN = 1'b0; b0.SYSCALL_ACK = 1'b0;
  endtask

  task automatic outs0(input string tag, input logic pcs, input logic [3:0] st,
                       input logic [3:0] fl, input logic so, input logic busy);
    chk({tag, ".pc_stall"}, 32'(b0.PC_STALL), 32'(pcs));
    chk({tag, ".stall"},    32'(b0.STALL),    32'(st));
    chk({tag, ".flush"},    32'(b0.FLUSH),    32'(fl));
    chk({tag, ".sysout"},   32'(b0.SYSCALL_OUT), 32'(so));
    chk({tag, ".busy"},     32'(b0.BUSY),     32'(busy));
  endtask

  initial begin
    RESET = 1'b0;
    idle0();
    b1.ID_RS = '0; b1.ID_RT = '0; b1.ID_USES_RT = 1'b0; b1.EX_MEMREAD = 1'b0;
    b1.EX_RD = '0; b1.BRANCH_TAKEN = 1'b0; b1.SYSCALL_IN = 1'b0; b1.SYSCALL_ACK = 1'b0;
    #3;
    outs0("reset", 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    chk("reset.cnt", 32'(b0.STALL_CNT), 32'd0);
    tick();
    tick();
    RESET = 1'b1;

    // Load-use on RS: one bubble
    tick();
    b0.EX_MEMREAD = 1'b1; b0.EX_RD = 5'd8; b0.ID_RS = 5'd8; b0.ID_RT = 5'd3; b0.ID_USES_RT = 1'b1;
    #1;
    outs0("lu_rs", 1'b1, 4'b0001, 4'b0010, 1'b0, 1'b0);
    tick();
    idle0();
    #1;
    outs0("lu_after", 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    chk("lu_after.cnt", 32'(b0.STALL_CNT), 32'd1);

    // Load into r0 is not a hazard
    b0.EX_MEMREAD = 1'b1; b0.EX_RD = 5'd0; b0.ID_RS = 5'd0; b0.ID_RT = 5'd0; b0.ID_USES_RT = 1'b1;
    #1;
    chk("lu_r0.pc_stall", 32'(b0.PC_STALL), 32'd0);
    // RT match ignored when RT is not read
    b0.EX_RD = 5'd9; b0.ID_RS = 5'd2; b0.ID_RT = 5'd9; b0.ID_USES_RT = 1'b0;
    #1;
    chk("lu_rt_unused.pc_stall", 32'(b0.PC_STALL), 32'd0);
    tick();
    chk("lu_none.cnt", 32'(b0.STALL_CNT), 32'd1);
    b0.ID_USES_RT = 1'b1;
    #1;
    outs0("lu_rt", 1'b1, 4'b0001, 4'b0010, 1'b0, 1'b0);
    tick();
    idle0();
    #1;
    chk("lu_rt.cnt", 32'(b0.STALL_CNT), 32'd2);

    // Branch beats syscall and load-use
    b0.BRANCH_TAKEN = 1'b1; b0.SYSCALL_IN = 1'b1;
    b0.EX_MEMREAD = 1'b1; b0.EX_RD = 5'd4; b0.ID_RS = 5'd4;
    #1;
    outs0("branch", 1'b0, 4'b0000, 4'b0011, 1'b0, 1'b0);
    tick();
    idle0();
    #1;
    chk("branch.busy", 32'(b0.BUSY), 32'd0);
    chk("branch.cnt", 32'(b0.STALL_CNT), 32'd2);

    // SYSCALL at T, ACK high in T+5
    b0.SYSCALL_IN = 1'b1;
    #1;
    outs0("sys_T", 1'b1, 4'b0001, 4'b0010, 1'b0, 1'b0);
    tick();
    idle0();
    b0.SYSCALL_ACK = 1'b1;
    #1;
    outs0("sys_T1", 1'b1, 4'b0001, 4'b0011, 1'b0, 1'b1);
    tick();
    b0.SYSCALL_ACK = 1'b0; b0.BRANCH_TAKEN = 1'b1; b0.SYSCALL_IN = 1'b1;
    #1;
    outs0("sys_T2", 1'b1, 4'b0001, 4'b0011, 1'b0, 1'b1);
    tick();
    idle0();
    #1;
    outs0("sys_T3", 1'b1, 4'b0001, 4'b0011, 1'b0, 1'b1);
    tick();
    #1;
    outs0("sys_T4", 1'b1, 4'b0001, 4'b0010, 1'b1, 1'b1);
    tick();
    b0.SYSCALL_ACK = 1'b1;
    #1;
    outs0("sys_T5", 1'b1, 4'b0001, 4'b0010, 1'b1, 1'b1);
    tick();
    idle0();
    #1;
    outs0("sys_T6", 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    chk("sys_T6.cnt", 32'(b0.STALL_CNT), 32'd8);

    // SYSCALL with ACK already high on the first SERVICE cycle
    b0.SYSCALL_IN = 1'b1;
    tick();
    idle0();
    tick();
    tick();
    tick();
    b0.SYSCALL_ACK = 1'b1;
    #1;
    outs0("ack_early_svc", 1'b1, 4'b0001, 4'b0010, 1'b1, 1'b1);
    tick();
    idle0();
    #1;
    outs0("ack_early_run", 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    chk("ack_early.cnt", 32'(b0.STALL_CNT), 32'd13);

    // Asynchronous reset during SERVICE
    b0.SYSCALL_IN = 1'b1;
    tick();
    idle0();
    tick();
    tick();
    tick();
    #1;
    chk("rst_svc.pre_sysout", 32'(b0.SYSCALL_OUT), 32'd1);
    #1;
    RESET = 1'b0;
    #1;
    outs0("rst_svc", 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    chk("rst_svc.cnt", 32'(b0.STALL_CNT), 32'd0);
    #1;
    RESET = 1'b1;
    tick();
    #1;
    chk("rst_svc.after_busy", 32'(b0.BUSY), 32'd0);

    // Saturation of a 4-bit counter
    b1.EX_MEMREAD = 1'b1; b1.EX_RD = 5'd7; b1.ID_RS = 5'd7;
    for (int unsigned i = 0; i < 10; i++) tick();
    #1;
    chk("sat.cnt10", 32'(b1.STALL_CNT), 32'd10);
    for (int unsigned i = 0; i < 10; i++) tick();
    #1;
    chk("sat.cnt20", 32'(b1.STALL_CNT), 32'd15);
    chk("sat.pc_stall", 32'(b1.PC_STALL), 32'd1);
    b1.EX_MEMREAD = 1'b0;
    tick();
    #1;
    chk("sat.hold", 32'(b1.STALL_CNT), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_controller.md
# hazard_controller

Parametrised pipeline hazard controller for the MIPS core, sitting beside the pipeline registers and driving their per-stage stall and flush controls. It detects load-use hazards, squashes wrong-path instructions on taken branches, and runs a drain-and-service sequence for SYSCALL with an explicit acknowledge handshake. It also keeps a saturating count of pipeline stall cycles for performance debug.

## Interface
- NUM_STAGES, 4: number of pipeline registers. Index 0=IF/ID, 1=ID/EX, 2=EX/MEM, 3=MEM/WB. Minimum 3.
- REG_W, 5: register-address width.
- CNT_W, 16: width of the stall-cycle counter.
- CLOCK  in  1  clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-low reset.
- ID_RS, ID_RT  in  REG_W each  source registers of the instruction in ID.
- ID_USES_RT  in  1  the ID instruction reads RT.
- EX_MEMREAD  in  1  the EX instruction is a load.
- EX_RD  in  REG_W  destination of the EX instruction.
- BRANCH_TAKEN  in  1  taken branch or jump resolved in EX this cycle.
- SYSCALL_IN  in  1  the instruction in ID is SYSCALL.
- SYSCALL_ACK  in  1  the environment has finished servicing the call.
- PC_STALL  out  1  hold the PC.
- STALL  out  NUM_STAGES  per-register hold.
- FLUSH  out  NUM_STAGES  per-register clear-to-bubble; FLUSH wins over STALL at a register.
- SYSCALL_OUT  out  1  registered; high throughout SERVICE.
- BUSY  out  1  state != RUN.
- STALL_CNT  out  CNT_W  saturating count of cycles with PC_STALL=1.

## Operation
- FSM states: RUN, DRAIN, SERVICE.
- Load-use term: lu = EX_MEMREAD & (EX_RD!=0) & (EX_RD==ID_RS | (ID_USES_RT & EX_RD==ID_RT)).
- RUN, priority branch > syscall > load-use, all outputs combinational:
  - BRANCH_TAKEN: FLUSH[0]=FLUSH[1]=1, no stall. SYSCALL_IN and lu are ignored because both instructions are wrong-path.
  - SYSCALL_IN: PC_STALL=1, STALL[0]=1, FLUSH[1]=1. Next state DRAIN, drain counter cleared.
  - lu: PC_STALL=1, STALL[0]=1, FLUSH[1]=1. State stays RUN.
- DRAIN:
  - Outputs: PC_STALL=1, STALL[0]=1, FLUSH[0]=1 (the SYSCALL is discarded), FLUSH[1]=1.
  - Lasts exactly NUM_STAGES-1 cycles, counted by a drain counter of width $clog2(NUM_STAGES), so that older instructions retire.
  - Then the FSM moves to SERVICE.
- SERVICE:
  - Outputs: SYSCALL_OUT=1, PC_STALL=1, STALL[0]=1, FLUSH[1]=1.
  - SYSCALL_ACK sampled high moves the FSM to RUN. The PC still holds SYSCALL+4, so fetch resumes there.
- In DRAIN and SERVICE, SYSCALL_IN, BRANCH_TAKEN and lu are ignored.
- STALL[i] and FLUSH[i] for i≥2 are held at 0 in all states.
- STALL_CNT increments on every posedge where PC_STALL=1 and saturates at 2^CNT_W-1. It never wraps.

## Timing
- Reset values:
  - State RUN, drain counter 0, SYSCALL_OUT=0, STALL_CNT=0, BUSY=0.
  - PC_STALL, STALL and FLUSH follow the RUN combinational terms.
- Reset asserted mid-DRAIN or mid-SERVICE: the FSM returns to RUN immediately (asynchronous), and SYSCALL_OUT drops without waiting for a clock edge.
- Load-use and branch responses have zero-cycle latency (combinational). A load-use produces exactly one bubble.
- SYSCALL timeline, with the detect cycle as T:
  - T: SYSCALL_IN high in ID.
  - T+1 to T+NUM_STAGES-1: DRAIN.
  - T+NUM_STAGES: SYSCALL_OUT rises (registered).
- SYSCALL_ACK:
  - An ACK already high on the first SERVICE cycle gives a one-cycle SERVICE.
  - After the ACK edge, SYSCALL_OUT falls and RUN resumes.
  - ACK outside SERVICE is ignored.

## Structure
- Shared package hazard_pkg holds:
  - the state enum {RUN, DRAIN, SERVICE};
  - stage-index constants IFID=0, IDEXE=1, EXMEM=2, MEMWB=3.
- Sub-module hazard_loaduse_detect holds the combinational lu comparator, parametrised by REG_W.
- The top module holds the FSM, the drain counter, the output decode and STALL_CNT.

## Test plan
- Load-use: EX_MEMREAD=1, EX_RD=8, ID_RS=8 → one cycle of PC_STALL=1, STALL=4'b0001, FLUSH=4'b0010. STALL_CNT=1 afterwards.
- Load-use with EX_RD=0, or ID_RT match with ID_USES_RT=0 → no stall.
- BRANCH_TAKEN together with SYSCALL_IN and lu → FLUSH=4'b0011, PC_STALL=0, BUSY stays 0.
- SYSCALL_IN at T, ACK held at T+5 → DRAIN for 3 cycles with FLUSH=4'b0011, SYSCALL_OUT high at T+4 and T+5, RUN at T+6, STALL_CNT=6.
- RESET pulsed low during SERVICE → SYSCALL_OUT, BUSY and STALL_CNT are 0 immediately, and the FSM is in RUN.
- CNT_W=4 with 20 consecutive stall cycles → STALL_CNT holds at 15.
